// File: rtl/tile_map_pkg.sv
// Shared constants, FSM encodings and tile-to-storage mapping for the screen tile map.
// The tile_loc function is also used by the pixel generator and its bench.
package tile_map_pkg;

   localparam int unsigned N_PER_ROW      = 60;
   localparam int unsigned N_ROWS         = 34;
   localparam int unsigned SPRITE_BITS    = 4;
   localparam int unsigned TILES_PER_WORD = 8;
   localparam int unsigned WORDS          = 256;
   localparam int unsigned WORD_BITS      = SPRITE_BITS * TILES_PER_WORD;
   localparam int unsigned ADDR_BITS      = 8;

   typedef logic [1:0] state_t;
   localparam state_t IDLE = 2'd0;
   localparam state_t RD   = 2'd1;
   localparam state_t MOD  = 2'd2;
   localparam state_t FILL = 2'd3;

   typedef struct packed {
      logic [7:0] word;
      logic [2:0] lane;
   } tile_loc_t;

   function automatic tile_loc_t tile_loc(input logic [5:0] x, input logic [5:0] y);
      logic [10:0] idx;
      tile_loc_t   loc;
      idx      = 11'(x) + 11'(N_PER_ROW) * 11'(y);
      loc.word = idx[10:3];
      loc.lane = idx[2:0];
      return loc;
   endfunction

   function automatic logic tile_oob(input logic [5:0] x, input logic [5:0] y);
      return (x >= 6'(N_PER_ROW)) || (y >= 6'(N_ROWS));
   endfunction

endpackage

// File: rtl/tile_map_ram.sv
// Simple dual-port tile storage: port A registered read-only (display), port B read/write (engine).
// Port A returns the old word when port B writes the same address in the same cycle.
module tile_map_ram #(
   parameter int unsigned DEPTH = 256,
   parameter int unsigned WIDTH = 32,
   parameter int unsigned AW    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    a_addr,
   output logic [WIDTH-1:0] a_data,
   input  logic [AW-1:0]    b_addr,
   input  logic             b_we,
   input  logic [WIDTH-1:0] b_wdata,
   output logic [WIDTH-1:0] b_rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) a_data <= '0;
      else     a_data <= mem[a_addr];
   end

   always_ff @(posedge clk) begin
      if (b_we) mem[b_addr] <= b_wdata;
      b_rdata <= mem[b_addr];
   end

endmodule

// File: rtl/tile_map_ctrl.sv
// Tile map controller: display read port plus single-tile read-modify-write and bulk-fill engine.
// Storage is not cleared by reset; a fill is expected after reset.
module tile_map_ctrl
   import tile_map_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rd_tile,
   output logic [31:0] rd_word,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [5:0]  wr_tile_x,
   input  logic [5:0]  wr_tile_y,
   input  logic [3:0]  wr_sprite,
   input  logic        fill_start,
   input  logic [3:0]  fill_sprite,
   output logic        busy,
   output logic        err_oob
);

   state_t      state;
   logic [7:0]  cnt;
   logic [7:0]  lat_word;
   logic [2:0]  lat_lane;
   logic [3:0]  lat_sprite;
   logic [3:0]  fill_val;
   tile_loc_t   loc;
   logic        oob;
   logic        hs;
   logic [7:0]  b_addr;
   logic        b_we;
   logic [31:0] b_wdata;
   logic [31:0] b_rdata;
   logic [31:0] merged;

   assign loc      = tile_loc(wr_tile_x, wr_tile_y);
   assign oob      = tile_oob(wr_tile_x, wr_tile_y);
   assign wr_ready = (state == IDLE) && !rst && !fill_start;
   assign busy     = (state != IDLE);
   assign hs       = wr_valid && wr_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         err_oob <= 1'b0;
      end else begin
         err_oob <= 1'b0;
         case (state)
            IDLE: begin
               if (fill_start) begin
                  fill_val <= fill_sprite;
                  cnt      <= '0;
                  state    <= FILL;
               end else if (hs) begin
                  if (oob) begin
                     err_oob <= 1'b1;
                  end else begin
                     lat_word   <= loc.word;
                     lat_lane   <= loc.lane;
                     lat_sprite <= wr_sprite;
                     state      <= RD;
                  end
               end
            end
            RD:   state <= MOD;
            MOD:  state <= IDLE;
            FILL: begin
               cnt <= cnt + 8'd1;
               if (cnt == 8'hFF) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      merged = b_rdata;
      merged[{lat_lane, 2'b00} +: 4] = lat_sprite;
   end

   // The RMW read is launched from IDLE using the live address so data is ready in RD;
   // writes are gated by rst so an abort never commits the in-flight word.
   always_comb begin
      b_addr  = lat_word;
      b_we    = 1'b0;
      b_wdata = merged;
      case (state)
         IDLE: b_addr = loc.word;
         MOD:  b_we   = !rst;
         FILL: begin
            b_addr  = cnt;
            b_we    = !rst;
            b_wdata = {8{fill_val}};
         end
         default: ;
      endcase
   end

   tile_map_ram #(
      .DEPTH (WORDS),
      .WIDTH (WORD_BITS),
      .AW    (ADDR_BITS)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .a_addr  (rd_tile),
      .a_data  (rd_word),
      .b_addr  (b_addr),
      .b_we    (b_we),
      .b_wdata (b_wdata),
      .b_rdata (b_rdata)
   );

endmodule

// File: tb/tb_tile_map_ctrl.sv
// Self-checking bench for tile_map_ctrl: table-driven single writes, fill sequences and reset abort,
// with a reference word model and an expected-read queue for the display port.
module tb_tile_map_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rd_tile;
   logic [31:0] rd_word;
   logic        wr_valid;
   logic        wr_ready;
   logic [5:0]  wr_tile_x;
   logic [5:0]  wr_tile_y;
   logic [3:0]  wr_sprite;
   logic        fill_start;
   logic [3:0]  fill_sprite;
   logic        busy;
   logic        err_oob;

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] model [256];
   logic [31:0] exp_q [$];

   typedef struct {
      logic [5:0]  x;
      logic [5:0]  y;
      logic [3:0]  s;
      logic        oob;
      int          word;
      logic [31:0] exp;
   } wvec_t;

   wvec_t vecs [8];

   always #5 clk = ~clk;

   tile_map_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .rd_tile     (rd_tile),
      .rd_word     (rd_word),
      .wr_valid    (wr_valid),
      .wr_ready    (wr_ready),
      .wr_tile_x   (wr_tile_x),
      .wr_tile_y   (wr_tile_y),
      .wr_sprite   (wr_sprite),
      .fill_start  (fill_start),
      .fill_sprite (fill_sprite),
      .busy        (busy),
      .err_oob     (err_oob)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic read_one(input int a, input logic [31:0] exp);
      rd_tile = 8'(a);
      exp_q.push_back(exp);
      @(posedge clk); #1;
      check($sformatf("rd_word[%0d]", a), rd_word, exp_q.pop_front());
   endtask

   task automatic read_range(input int lo, input int hi);
      for (int a = lo; a <= hi; a++) read_one(a, model[a]);
   endtask

   task automatic write_tile(input logic [5:0] x, input logic [5:0] y, input logic [3:0] s);
      logic oob;
      int   idx;
      int   guard;
      oob = (x >= 6'd60) || (y >= 6'd34);
      wr_tile_x = x;
      wr_tile_y = y;
      wr_sprite = s;
      wr_valid  = 1'b1;
      #1;
      guard = 0;
      while (!wr_ready && guard < 600) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!wr_ready) begin
         check("wr_ready_timeout", {31'd0, wr_ready}, 32'd1);
         wr_valid = 1'b0;
         return;
      end
      @(posedge clk); #1;
      wr_valid = 1'b0;
      check("err_oob", {31'd0, err_oob}, {31'd0, oob});
      if (oob) begin
         check("ready_after_oob", {31'd0, wr_ready}, 32'd1);
         @(posedge clk); #1;
         check("err_oob_pulse_end", {31'd0, err_oob}, 32'd0);
      end else begin
         check("ready_rd", {31'd0, wr_ready}, 32'd0);
         @(posedge clk); #1;
         check("ready_mod", {31'd0, wr_ready}, 32'd0);
         @(posedge clk); #1;
         check("ready_back", {31'd0, wr_ready}, 32'd1);
         idx = int'(x) + 60 * int'(y);
         model[idx / 8][(idx % 8) * 4 +: 4] = s;
      end
   endtask

   task automatic count_busy(input logic [3:0] s);
      int cnt;
      cnt = 0;
      while (busy && cnt < 400) begin
         cnt++;
         // a stray start while busy must be ignored
         if (cnt == 50) begin
            fill_start  = 1'b1;
            fill_sprite = ~s;
         end else begin
            fill_start  = 1'b0;
         end
         if (cnt == 10) check("ready_while_busy", {31'd0, wr_ready}, 32'd0);
         @(posedge clk); #1;
      end
      fill_start = 1'b0;
      check("busy_cycles", cnt, 256);
      for (int w = 0; w < 256; w++) model[w] = {8{s}};
   endtask

   task automatic do_fill(input logic [3:0] s);
      fill_start  = 1'b1;
      fill_sprite = s;
      #1;
      check("ready_on_start", {31'd0, wr_ready}, 32'd0);
      @(posedge clk); #1;
      fill_start = 1'b0;
      count_busy(s);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vecs[0] = '{x: 6'd5,  y: 6'd0,  s: 4'h9, oob: 1'b0, word: 0,   exp: 32'h0090_0000};
      vecs[1] = '{x: 6'd13, y: 6'd2,  s: 4'hC, oob: 1'b0, word: 16,  exp: 32'h00C0_0000};
      vecs[2] = '{x: 6'd59, y: 6'd33, s: 4'hF, oob: 1'b0, word: 254, exp: 32'hF000_0000};
      vecs[3] = '{x: 6'd60, y: 6'd0,  s: 4'h3, oob: 1'b1, word: 0,   exp: 32'h0090_0000};
      vecs[4] = '{x: 6'd0,  y: 6'd34, s: 4'h7, oob: 1'b1, word: 254, exp: 32'hF000_0000};
      vecs[5] = '{x: 6'd0,  y: 6'd1,  s: 4'h5, oob: 1'b0, word: 7,   exp: 32'h0005_0000};
      vecs[6] = '{x: 6'd7,  y: 6'd0,  s: 4'h1, oob: 1'b0, word: 0,   exp: 32'h1090_0000};
      vecs[7] = '{x: 6'd63, y: 6'd63, s: 4'h2, oob: 1'b1, word: 16,  exp: 32'h00C0_0000};

      rst         = 1'b1;
      rd_tile     = '0;
      wr_valid    = 1'b0;
      wr_tile_x   = '0;
      wr_tile_y   = '0;
      wr_sprite   = '0;
      fill_start  = 1'b0;
      fill_sprite = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_wr_ready", {31'd0, wr_ready}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_err_oob", {31'd0, err_oob}, 32'd0);
      check("reset_rd_word", rd_word, 32'd0);
      rst = 1'b0;
      #1;
      check("idle_wr_ready", {31'd0, wr_ready}, 32'd1);

      do_fill(4'h0);
      for (int i = 0; i < 8; i++) begin
         write_tile(vecs[i].x, vecs[i].y, vecs[i].s);
         read_one(vecs[i].word, vecs[i].exp);
      end
      read_range(0, 255);

      do_fill(4'hA);
      read_range(0, 255);

      fill_start  = 1'b1;
      fill_sprite = 4'h5;
      wr_tile_x   = 6'd2;
      wr_tile_y   = 6'd0;
      wr_sprite   = 4'hE;
      wr_valid    = 1'b1;
      #1;
      check("ready_fill_vs_write", {31'd0, wr_ready}, 32'd0);
      @(posedge clk); #1;
      fill_start = 1'b0;
      count_busy(4'h5);
      write_tile(6'd2, 6'd0, 4'hE);
      read_one(0, 32'h5555_5E55);
      read_range(0, 255);

      fill_start  = 1'b1;
      fill_sprite = 4'hC;
      @(posedge clk); #1;
      fill_start = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_wr_ready", {31'd0, wr_ready}, 32'd0);
      check("abort_rd_word", rd_word, 32'd0);
      rst = 1'b0;
      #1;
      check("abort_ready_back", {31'd0, wr_ready}, 32'd1);
      for (int w = 0; w < 100; w++) model[w] = 32'hCCCC_CCCC;
      read_range(0, 255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tile_map_ctrl.md
Name: tile_map_ctrl

Overview:
Owns the screen tile map: one 4-bit sprite ID per 32x32 tile on the 60x34 tile grid, packed 8 tiles per 32-bit word.
- Display side: presents a tile word index and reads back the packed word that feeds the pixel generator's sprite-select input.
- Control side: writes single tiles through a valid/ready handshake, or floods the whole map with one sprite via a bulk-fill engine.

Parameters:
N_PER_ROW, 60, tiles per row
N_ROWS, 34, tile rows (last row partially visible)
SPRITE_BITS, 4, bits per sprite ID
TILES_PER_WORD, 8, sprite IDs per storage word
WORDS, 256, storage depth (2040 tiles use words 0..254; word 255 is spare)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rd_tile  in  8  display word index (0..255)
rd_word  out  32  packed word for rd_tile; lane k occupies bits [4k+3:4k]
wr_valid  in  1  single-tile write request
wr_ready  out  1  write accepted when wr_valid && wr_ready
wr_tile_x  in  6  tile column
wr_tile_y  in  6  tile row
wr_sprite  in  4  sprite ID to store
fill_start  in  1  one-cycle pulse: start bulk fill
fill_sprite  in  4  sprite ID for bulk fill, sampled on fill_start
busy  out  1  engine not idle
err_oob  out  1  one-cycle pulse: an accepted write was out of bounds

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-high (ports clk, rst).
- Reset values: FSM=IDLE, rd_word=0, wr_ready=0 during the reset cycle (1 from the first IDLE cycle after), busy=0, err_oob=0.
- Reset does not clear storage; software issues a fill after reset. Reset asserted mid-operation aborts at once to IDLE, and words already written keep their values.
- Storage: simple dual-port RAM, WORDS x 32, 1-cycle registered read on both ports.
  - Port A is the display reader. Port B is the engine, which does read then write.
  - Read-during-write to the same address on port A returns OLD data.
- Display read: rd_word(t+1) = mem[rd_tile(t)]. Fixed latency of 1 cycle. Never stalled by engine activity.
- Address math for writes: idx = wr_tile_x + N_PER_ROW*wr_tile_y (11 bits, unsigned); word = idx[10:3]; lane = idx[2:0].
- Out of bounds: a write is OOB when wr_tile_x >= 60 or wr_tile_y >= 34.
- FSM states: IDLE, RD, MOD, FILL.
  - IDLE: wr_ready=1, busy=0.
    - fill_start=1: latch fill_sprite, clear counter to 0, go to FILL. fill_start wins over a simultaneous wr_valid, and wr_ready is 0 in that cycle.
    - Else, on a handshake that is OOB: pulse err_oob on the next cycle, stay in IDLE, no write.
    - Else, on an in-bounds handshake: latch word, lane and sprite, issue the port B read, go to RD.
  - RD: wait for the read data (1 cycle), go to MOD. busy=1, wr_ready=0.
  - MOD: write the read word back with only lane replaced by the latched sprite, go to IDLE. Total 3 cycles per single write.
  - FILL: write the sprite replicated 8 times to mem[counter], then increment. After writing word 255, go to IDLE. busy=1 for exactly 256 cycles.
- fill_start while busy is ignored. wr_valid while busy is held off (wr_ready=0) and must not be dropped by the requester.
- The write handshake follows standard valid/ready rules: inputs are sampled only on the handshake cycle.

Decomposition:
- Package tile_map_pkg:
  - Constants N_PER_ROW, N_ROWS, SPRITE_BITS, TILES_PER_WORD, WORDS.
  - State enum {IDLE, RD, MOD, FILL}.
  - Function for the tile to (word, lane) mapping, shared with the pixel generator and its bench.
- Sub-module tile_map_ram: dual-port, registered read, old-data-on-collision. Maps to block RAM.

Test Plan:
- Reset, then fill 0x0, then write (x=5, y=0, sprite=9) -> after idle, rd_tile=0 returns 0x00900000. wr_ready is low for 2 cycles after the handshake.
- Write (x=13, y=2, sprite=0xC): idx=133 -> word 16 returns 0x00C00000, and neighbouring words 15 and 17 are unchanged.
- Write (x=59, y=33, sprite=0xF): idx=2039 -> word 254 returns 0xF0000000. Then write (60, 0, 3) -> err_oob pulses once and no word changes.
- fill_start with 0xA -> busy high exactly 256 cycles. Afterwards every rd_tile 0..255 returns 0xAAAAAAAA, with rd_word latency of 1 cycle.
- fill_start and wr_valid asserted in the same IDLE cycle -> fill runs and the write waits. The write completes after busy falls, and its lane overlays the fill pattern.
- Assert rst at fill counter 100 -> busy=0 on the next cycle. Words 0..99 hold the new pattern and 100..255 the old.
